// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int FRAME_BITS = 1 + DATA_BITS + 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus falling-edge detect.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_prev;

    // All flops reset to the idle level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
            rx_prev <= LINE_IDLE;
        end else begin
            meta    <= rx;
            rx_s    <= meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM, shift register and pulse outputs.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR,
    output logic       RX_BUSY
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
        $error("CLKS_PER_BIT must be even and at least 4");
    end

    logic rx_s;
    logic fall;

    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [2:0]           idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [7:0]           data_next;
    logic                 status_next;
    logic                 err_next;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (UART_RX),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            RX_DATA   <= 8'h00;
            RX_STATUS <= 1'b0;
            RX_ERR    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift     <= shift_next;
            RX_DATA   <= data_next;
            RX_STATUS <= status_next;
            RX_ERR    <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        idx_next    = idx;
        shift_next  = shift;
        data_next   = RX_DATA;
        status_next = 1'b0;
        err_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s == START_LEVEL) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_s;
                    if (idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    // Returning at mid-stop leaves half a bit to catch the next start edge.
                    if (rx_s == STOP_LEVEL) begin
                        data_next   = shift;
                        status_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign RX_BUSY = (state != IDLE);

endmodule
